// File: rtl/conv_layer2.sv
// conv_layer2 - layer-2 3x3 convolution row engine, 4 input channels.
//
// Each enabled cycle one zero-padded input row (14 pixels per channel) is
// combined with the two preceding rows under the three kernel-row weight
// buses. The result is 12 signed 16-bit output-column partial sums.
//
// Ports:
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   en                   pipeline advance enable (0 = hold everything)
//   Ifmap_shift_in_0..3  input row per channel; pixel j at [111-8j -: 8], unsigned
//   Filtr_in_0..2        kernel rows top..bottom; weight (c,ch) at [47-16c-4ch -: 4], signed
//   Psum_out_sum         12 sums; column i at [191-16i -: 16], signed
//
// Parameter OUT_DELAY adds extra output register stages.
// Macro CONV2_SAT_EN: defined saturates the final sum to signed 16 bits;
// undefined wraps it (keeps the low 16 bits).
module conv_layer2 #(
  parameter int unsigned OUT_DELAY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [111:0] Ifmap_shift_in_0,
  input  logic [111:0] Ifmap_shift_in_1,
  input  logic [111:0] Ifmap_shift_in_2,
  input  logic [111:0] Ifmap_shift_in_3,
  input  logic [47:0]  Filtr_in_0,
  input  logic [47:0]  Filtr_in_1,
  input  logic [47:0]  Filtr_in_2,
  output logic [191:0] Psum_out_sum
);

  localparam int unsigned NCOL = 12;

  // ifm[ch] is the row for channel ch
  logic [3:0][111:0] ifm;
  assign ifm = {Ifmap_shift_in_3, Ifmap_shift_in_2, Ifmap_shift_in_1, Ifmap_shift_in_0};

  // One kernel row applied to one output column: 12 products of
  // zero-extended pixel x sign-extended weight (13-bit), summed in 18 bits.
  function automatic logic signed [17:0] row_term(
    input logic [3:0][111:0] px,
    input logic [47:0]       wb,
    input int unsigned       col
  );
    logic signed [17:0] s;
    logic [7:0]         p;
    logic signed [3:0]  w;
    logic signed [12:0] prod;
    s = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      for (int unsigned ch = 0; ch < 4; ch++) begin
        p    = px[ch][111 - 8*(col + c) -: 8];
        w    = wb[47 - 16*c - 4*ch -: 4];
        prod = $signed({1'b0, p}) * w;
        s    = s + 18'(prod);
      end
    end
    return s;
  endfunction

  logic signed [17:0] acc0_q [NCOL];
  logic signed [17:0] acc1_q [NCOL];
  logic signed [17:0] acc0_d [NCOL];
  logic signed [17:0] acc1_d [NCOL];
  logic [191:0]       out_d;
  // dly_q[0] is the main output register; higher entries are the extra stages
  logic [191:0]       dly_q [OUT_DELAY+1];

  always_comb begin
    logic signed [17:0] sum_v;
    out_d = '0;
    sum_v = '0;
    for (int unsigned i = 0; i < NCOL; i++) begin
      acc0_d[i] = row_term(ifm, Filtr_in_0, i);
      acc1_d[i] = acc0_q[i] + row_term(ifm, Filtr_in_1, i);
      sum_v     = acc1_q[i] + row_term(ifm, Filtr_in_2, i);
`ifdef CONV2_SAT_EN
      if (sum_v > 18'sd32767)
        out_d[191 - 16*i -: 16] = 16'h7FFF;
      else if (sum_v < -18'sd32768)
        out_d[191 - 16*i -: 16] = 16'h8000;
      else
        out_d[191 - 16*i -: 16] = sum_v[15:0];
`else
      out_d[191 - 16*i -: 16] = sum_v[15:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCOL; i++) begin
        acc0_q[i] <= '0;
        acc1_q[i] <= '0;
      end
      for (int unsigned k = 0; k <= OUT_DELAY; k++) begin
        dly_q[k] <= '0;
      end
    end else if (en) begin
      acc0_q   <= acc0_d;
      acc1_q   <= acc1_d;
      dly_q[0] <= out_d;
      for (int unsigned k = 1; k <= OUT_DELAY; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
    end
  end

  assign Psum_out_sum = dly_q[OUT_DELAY];

endmodule

// File: tb/tb_conv_layer2.sv
// Directed bench for conv_layer2: two instances share stimulus, one with
// OUT_DELAY=0 and one with OUT_DELAY=2.
module tb_conv_layer2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [111:0] if0 = '0, if1 = '0, if2 = '0, if3 = '0;
  logic [47:0]  f0 = '0, f1 = '0, f2 = '0;
  logic [191:0] out0, out2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_layer2 #(.OUT_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .Ifmap_shift_in_0(if0), .Ifmap_shift_in_1(if1),
    .Ifmap_shift_in_2(if2), .Ifmap_shift_in_3(if3),
    .Filtr_in_0(f0), .Filtr_in_1(f1), .Filtr_in_2(f2),
    .Psum_out_sum(out0)
  );

  conv_layer2 #(.OUT_DELAY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .Ifmap_shift_in_0(if0), .Ifmap_shift_in_1(if1),
    .Ifmap_shift_in_2(if2), .Ifmap_shift_in_3(if3),
    .Filtr_in_0(f0), .Filtr_in_1(f1), .Filtr_in_2(f2),
    .Psum_out_sum(out2)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [111:0] row_all(input logic [7:0] v);
    logic [111:0] r;
    for (int j = 0; j < 14; j++) r[111 - 8*j -: 8] = v;
    return r;
  endfunction

  function automatic logic [191:0] bcast(input logic [15:0] v);
    logic [191:0] r;
    for (int i = 0; i < 12; i++) r[191 - 16*i -: 16] = v;
    return r;
  endfunction

  task automatic rows(input logic [111:0] a, input logic [111:0] b,
                      input logic [111:0] c, input logic [111:0] d);
    if0 = a; if1 = b; if2 = c; if3 = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [111:0] imp_row;
  logic [191:0] imp_exp;
  logic [15:0]  ovf_exp;

  initial begin
    imp_row = '0;
    imp_row[111 - 8*5 -: 8] = 8'd10;
    imp_exp = '0;
    for (int i = 3; i <= 5; i++) imp_exp[191 - 16*i -: 16] = 16'd10;
`ifdef CONV2_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'hFB04;
`endif

    // reset state
    #12;
    check("reset_d0", out0, '0);
    check("reset_d2", out2, '0);
    rst_n = 1'b1;
    en    = 1'b1;

    // single-pixel impulse, channel-0 weights 1 in all kernel rows
    f0 = 48'h1000_1000_1000; f1 = 48'h1000_1000_1000; f2 = 48'h1000_1000_1000;
    rows('0, '0, '0, '0); tick();
    tick();
    rows(imp_row, '0, '0, '0); tick();
    check("imp_d0_t3", out0, imp_exp);
    check("imp_d2_t3", out2, '0);
    rows('0, '0, '0, '0); tick();
    tick();
    check("imp_d2_t5", out2, imp_exp);
    tick();
    check("imp_d0_t6", out0, '0);
    tick();
    check("imp_d2_t7", out2, imp_exp);
    tick();
    check("imp_d2_t8", out2, '0);

    // row alignment: top kernel row only, rows 2,0,0
    f0 = 48'h1111_1111_1111; f1 = '0; f2 = '0;
    rows(row_all(8'd2), row_all(8'd2), row_all(8'd2), row_all(8'd2)); tick();
    rows('0, '0, '0, '0); tick();
    tick();
    check("align_k0", out0, bcast(16'd24));
    // bottom kernel row only: row A shows up at once, nothing after C
    f0 = '0; f2 = 48'h1111_1111_1111;
    rows(row_all(8'd2), row_all(8'd2), row_all(8'd2), row_all(8'd2)); tick();
    check("align_k2_a", out0, bcast(16'd24));
    rows('0, '0, '0, '0); tick();
    tick();
    check("align_k2_c", out0, '0);

    // signed weights: -8 everywhere, pixels 1
    f0 = 48'h8888_8888_8888; f1 = 48'h8888_8888_8888; f2 = 48'h8888_8888_8888;
    rows(row_all(8'd1), row_all(8'd1), row_all(8'd1), row_all(8'd1));
    tick(); tick(); tick();
    check("signed_m288", out0, bcast(16'hFEE0));

    // overflow: 255 * 7 * 36 = 64260
    f0 = 48'h7777_7777_7777; f1 = 48'h7777_7777_7777; f2 = 48'h7777_7777_7777;
    rows(row_all(8'd255), row_all(8'd255), row_all(8'd255), row_all(8'd255));
    tick(); tick(); tick();
    check("overflow", out0, bcast(ovf_exp));

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_d0", out0, '0);
    check("rst_async_d2", out2, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rows('0, '0, '0, '0); tick();
    check("rst_hold_d0", out0, '0);
    check("rst_hold_d2", out2, '0);

    // stall: all weights 1, rows of constant v give 12*v per kernel row
    f0 = 48'h1111_1111_1111; f1 = 48'h1111_1111_1111; f2 = 48'h1111_1111_1111;
    for (int v = 1; v <= 3; v++) begin
      rows(row_all(8'(v)), row_all(8'(v)), row_all(8'(v)), row_all(8'(v)));
      tick();
    end
    check("pre_stall_d0", out0, bcast(16'd72));
    check("pre_stall_d2", out2, bcast(16'd12));
    en = 1'b0;
    rows(row_all(8'd9), row_all(8'd9), row_all(8'd9), row_all(8'd9));
    tick(); tick(); tick();
    check("stall_d0", out0, bcast(16'd72));
    check("stall_d2", out2, bcast(16'd12));
    en = 1'b1;
    rows(row_all(8'd4), row_all(8'd4), row_all(8'd4), row_all(8'd4)); tick();
    check("resume1_d0", out0, bcast(16'd108));
    check("resume1_d2", out2, bcast(16'd36));
    rows('0, '0, '0, '0); tick();
    check("resume2_d0", out0, bcast(16'd84));
    check("resume2_d2", out2, bcast(16'd72));
    tick();
    check("resume3_d0", out0, bcast(16'd48));
    check("resume3_d2", out2, bcast(16'd108));
    tick(); tick(); tick();
    check("decay_d0", out0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
